// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants.
package pipe_pkg;
  typedef logic [1:0] tnew_t;
  typedef logic [4:0] reg_addr_t;

  localparam tnew_t       TUSE_NONE = 2'd3;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // One source operand against the two in-flight producers; $0 never hazards.
  function automatic logic src_hazard(input reg_addr_t addr, input tnew_t tuse,
                                      input reg_addr_t e_a3, input tnew_t e_tnew,
                                      input reg_addr_t m_a3, input tnew_t m_tnew);
    return (addr != '0) && (tuse != TUSE_NONE) &&
           (((addr == e_a3) && (tuse < e_tnew)) ||
            ((addr == m_a3) && (tuse < m_tnew)));
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/execute/CP0 <-> stall controller bundle.
// Stall counters appear only with PIPE_CTRL_STALL_CNT_EN.
interface pipe_ctrl_if;
  import pipe_pkg::*;
  reg_addr_t D_rsAddr, D_rtAddr, E_A3, M_A3;
  tnew_t     D_rsTuse, D_rtTuse, E_Tnew, M_Tnew;
  logic      D_isMD, E_mdStart, E_mdIsDiv, M_excReq;
  logic      D_REG_STALL, E_REG_FLUSH, intReq, E_mdBusy;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stallCount, mdStallCount;

  modport master (output D_rsAddr, D_rtAddr, D_rsTuse, D_rtTuse, D_isMD, E_A3, M_A3,
                         E_Tnew, M_Tnew, E_mdStart, E_mdIsDiv, M_excReq,
                  input  D_REG_STALL, E_REG_FLUSH, intReq, E_mdBusy, stallCount, mdStallCount);
  modport slave  (input  D_rsAddr, D_rtAddr, D_rsTuse, D_rtTuse, D_isMD, E_A3, M_A3,
                         E_Tnew, M_Tnew, E_mdStart, E_mdIsDiv, M_excReq,
                  output D_REG_STALL, E_REG_FLUSH, intReq, E_mdBusy, stallCount, mdStallCount);
`else
  modport master (output D_rsAddr, D_rtAddr, D_rsTuse, D_rtTuse, D_isMD, E_A3, M_A3,
                         E_Tnew, M_Tnew, E_mdStart, E_mdIsDiv, M_excReq,
                  input  D_REG_STALL, E_REG_FLUSH, intReq, E_mdBusy);
  modport slave  (input  D_rsAddr, D_rtAddr, D_rsTuse, D_rtTuse, D_isMD, E_A3, M_A3,
                         E_Tnew, M_Tnew, E_mdStart, E_mdIsDiv, M_excReq,
                  output D_REG_STALL, E_REG_FLUSH, intReq, E_mdBusy);
`endif
endinterface

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy scheduler: cycle countdown with exception cancel of new starts.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  input  logic cancel_i,
  output logic busy_o
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  logic [CW-1:0] cnt_q;
  md_state_e     state_q;
  logic [CW-1:0] ld_val;

  assign ld_val = is_div_i ? DIV_LD : MULT_LD;

  // A start alongside an exception belongs to a cancelled instruction; a
  // countdown already running is for a committed op and keeps going.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= MD_IDLE;
    end else if (start_i && !cancel_i) begin
      cnt_q   <= ld_val;
      state_q <= (ld_val != '0) ? MD_BUSY : MD_IDLE;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) state_q <= MD_IDLE;
    end
  end

  assign busy_o = (state_q == MD_BUSY);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use + MDU hazards, exception override.
// Optional stall counters with PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  pipe_ctrl_if.slave pif
);
  logic load_use, md_haz, stall, md_busy;

  assign load_use = src_hazard(pif.D_rsAddr, pif.D_rsTuse, pif.E_A3, pif.E_Tnew, pif.M_A3, pif.M_Tnew)
                  | src_hazard(pif.D_rtAddr, pif.D_rtTuse, pif.E_A3, pif.E_Tnew, pif.M_A3, pif.M_Tnew);

  md_busy_cnt #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk      (clk),
    .rst_n    (reset),
    .start_i  (pif.E_mdStart),
    .is_div_i (pif.E_mdIsDiv),
    .cancel_i (pif.M_excReq),
    .busy_o   (md_busy)
  );

  assign md_haz = pif.D_isMD && (md_busy || pif.E_mdStart);
  // Exception entry flushes everything, so stalling that cycle would be wrong.
  assign stall  = (load_use || md_haz) && !pif.M_excReq;

  assign pif.intReq      = pif.M_excReq;
  assign pif.D_REG_STALL = stall;
  assign pif.E_REG_FLUSH = stall;
  assign pif.E_mdBusy    = md_busy;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, md_stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
      if (md_haz) md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
    end
  end

  assign pif.stallCount   = stall_cnt_q;
  assign pif.mdStallCount = md_stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: hazard vector table, random run vs. cycle-index model, MDU corner sequences.
module tb_pipe_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if pif ();
  pipe_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(rst_n), .pif(pif));

  typedef struct {
    logic [4:0] rs_a, rt_a, e_a3, m_a3;
    logic [1:0] rs_tu, rt_tu, e_tn, m_tn;
    logic       is_md, exc;
    logic       x_stall, x_int;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    pif.D_rsAddr = '0; pif.D_rtAddr = '0; pif.D_rsTuse = 2'd3; pif.D_rtTuse = 2'd3;
    pif.D_isMD = 1'b0; pif.E_A3 = '0; pif.M_A3 = '0; pif.E_Tnew = '0; pif.M_Tnew = '0;
    pif.E_mdStart = 1'b0; pif.E_mdIsDiv = 1'b0; pif.M_excReq = 1'b0;
  endtask

  function automatic logic ref_src(input logic [4:0] a, input logic [1:0] tu,
                                   input logic [4:0] ea, input logic [1:0] et,
                                   input logic [4:0] ma, input logic [1:0] mt);
    if (a == 0) return 1'b0;
    return (a == ea && int'(tu) < int'(et)) || (a == ma && int'(tu) < int'(mt));
  endfunction

  // Model: absolute edge index; busy while the current index precedes the finish edge.
  int ecnt = 0;
  int done_edge = 0;
  int m_stall = 0, m_mdstall = 0;

  initial begin
    logic exp_stall, exp_busy, lu, mdh;
    int nb;
    idle_in();
    vecs[0] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{5'd5, 5'd0, 5'd0, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd0, 5'd0, 5'd5, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd3, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd0, 5'd7, 5'd0, 5'd7, 2'd3, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{5'd0, 5'd7, 5'd0, 5'd7, 2'd3, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{5'd9, 5'd9, 5'd3, 5'd9, 2'd1, 2'd1, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state
    #12;
    chk("rst_busy", pif.E_mdBusy, 0);
    chk("rst_stall", pif.D_REG_STALL, 0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("rst_scnt", pif.stallCount, 0);
    chk("rst_mdcnt", pif.mdStallCount, 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // vector table, MDU idle
    foreach (vecs[i]) begin
      @(negedge clk);
      pif.D_rsAddr = vecs[i].rs_a; pif.D_rtAddr = vecs[i].rt_a;
      pif.D_rsTuse = vecs[i].rs_tu; pif.D_rtTuse = vecs[i].rt_tu;
      pif.E_A3 = vecs[i].e_a3; pif.M_A3 = vecs[i].m_a3;
      pif.E_Tnew = vecs[i].e_tn; pif.M_Tnew = vecs[i].m_tn;
      pif.D_isMD = vecs[i].is_md; pif.M_excReq = vecs[i].exc;
      #1;
      chk($sformatf("vec%0d_stall", i), pif.D_REG_STALL, vecs[i].x_stall);
      chk($sformatf("vec%0d_flush", i), pif.E_REG_FLUSH, vecs[i].x_stall);
      chk($sformatf("vec%0d_int", i), pif.intReq, vecs[i].x_int);
    end
    @(negedge clk); idle_in();
    repeat (2) @(posedge clk);

    // randomized run against the model; counters re-zeroed with a reset pulse
    @(negedge clk); rst_n = 1'b0; #1 rst_n = 1'b1;
    ecnt = 0; done_edge = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      pif.D_rsAddr = 5'($urandom_range(0, 3)); pif.D_rtAddr = 5'($urandom_range(0, 3));
      pif.E_A3 = 5'($urandom_range(0, 3)); pif.M_A3 = 5'($urandom_range(0, 3));
      pif.D_rsTuse = 2'($urandom_range(0, 3)); pif.D_rtTuse = 2'($urandom_range(0, 3));
      pif.E_Tnew = 2'($urandom_range(0, 3)); pif.M_Tnew = 2'($urandom_range(0, 3));
      pif.D_isMD = 1'($urandom_range(0, 1));
      pif.E_mdStart = ($urandom_range(0, 7) == 0);
      pif.E_mdIsDiv = 1'($urandom_range(0, 1));
      pif.M_excReq = ($urandom_range(0, 7) == 0);
      #1;
      lu = ref_src(pif.D_rsAddr, pif.D_rsTuse, pif.E_A3, pif.E_Tnew, pif.M_A3, pif.M_Tnew) ||
           ref_src(pif.D_rtAddr, pif.D_rtTuse, pif.E_A3, pif.E_Tnew, pif.M_A3, pif.M_Tnew);
      exp_busy  = (ecnt < done_edge);
      mdh       = pif.D_isMD && (exp_busy || pif.E_mdStart);
      exp_stall = (lu || mdh) && !pif.M_excReq;
      chk("rnd_busy", pif.E_mdBusy, exp_busy);
      chk("rnd_stall", pif.D_REG_STALL, exp_stall);
      chk("rnd_flush", pif.E_REG_FLUSH, exp_stall);
      chk("rnd_int", pif.intReq, pif.M_excReq);
      @(posedge clk);
      ecnt++;
      if (exp_stall) begin m_stall++; if (mdh) m_mdstall++; end
      if (pif.E_mdStart && !pif.M_excReq) done_edge = ecnt + (pif.E_mdIsDiv ? DC : MC);
    end
`ifdef PIPE_CTRL_STALL_CNT_EN
    #1;
    chk("rnd_scnt", pif.stallCount, 32'(m_stall));
    chk("rnd_mdcnt", pif.mdStallCount, 32'(m_mdstall));
`endif
    @(negedge clk); idle_in();
    repeat (DC + 2) @(posedge clk);

    // divide with mfhi held in D
    @(negedge clk);
    pif.E_mdStart = 1'b1; pif.E_mdIsDiv = 1'b1; pif.D_isMD = 1'b1;
    #1 chk("div_start_stall", pif.D_REG_STALL, 1);
    @(negedge clk); pif.E_mdStart = 1'b0;
    nb = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (pif.E_mdBusy) nb++;
      chk("div_stall_eq_busy", pif.D_REG_STALL, (nb > k) ? 1 : 0);
      @(negedge clk);
    end
    chk("div_busy_cycles", nb, DC);
    idle_in();

    // start cancelled by same-cycle exception
    @(negedge clk);
    pif.E_mdStart = 1'b1; pif.D_isMD = 1'b1; pif.M_excReq = 1'b1;
    #1;
    chk("cancel_int", pif.intReq, 1);
    chk("cancel_stall", pif.D_REG_STALL, 0);
    chk("cancel_flush", pif.E_REG_FLUSH, 0);
    @(negedge clk); idle_in();
    #1 chk("cancel_no_load", pif.E_mdBusy, 0);

    // exception while busy does not clear a running mult (5,4,3 | exc | 2,1,0)
    @(negedge clk); pif.E_mdStart = 1'b1;
    @(negedge clk); pif.E_mdStart = 1'b0;
    #1 chk("mul_busy5", pif.E_mdBusy, 1);
    repeat (2) @(negedge clk);
    pif.M_excReq = 1'b1;
    #1 chk("mul_busy3_exc", pif.E_mdBusy, 1);
    @(negedge clk); pif.M_excReq = 1'b0;
    #1 chk("mul_busy2", pif.E_mdBusy, 1);
    @(negedge clk); #1 chk("mul_busy1", pif.E_mdBusy, 1);
    @(negedge clk); #1 chk("mul_idle", pif.E_mdBusy, 0);

    // asynchronous reset mid-mult at cnt=4
    @(negedge clk); pif.E_mdStart = 1'b1;
    @(negedge clk); pif.E_mdStart = 1'b0;
    @(negedge clk); #1 chk("arst_busy4", pif.E_mdBusy, 1);
    rst_n = 1'b0;
    #1 chk("arst_drop", pif.E_mdBusy, 0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("arst_scnt", pif.stallCount, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1 chk("arst_idle", pif.E_mdBusy, 0);

`ifdef PIPE_CTRL_STALL_CNT_EN
    // 7 load-use stalls then 5 MDU stalls
    @(negedge clk);
    pif.D_rsAddr = 5'd5; pif.D_rsTuse = 2'd0; pif.E_A3 = 5'd5; pif.E_Tnew = 2'd2;
    repeat (7) @(negedge clk);
    idle_in(); pif.E_mdStart = 1'b1;
    @(negedge clk); pif.E_mdStart = 1'b0; pif.D_isMD = 1'b1;
    for (int k = 0; k < 20 && pif.E_mdBusy; k++) @(negedge clk);
    idle_in();
    #1;
    chk("cnt_stall12", pif.stallCount, 12);
    chk("cnt_md5", pif.mdStallCount, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
